// File: rtl/kmeans_apb_pkg.sv
// Shared types and default sizing for the k-means APB command master.
// No logic of its own; imported by the FIFO and the master.
// Holds the transfer FSM encoding and the timeout counter sizing helper.
package kmeans_apb_pkg;

    // Default sizing, used as parameter defaults by the modules below.
    localparam int DEF_ADDR_WIDTH     = 8;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    // Transfer sequencer states: one APB transfer in flight at most.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    // Width of a counter able to hold the value 0..cycles inclusive.
    function automatic int timer_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/kmeans_cmd_fifo.sv
// Command FIFO: synchronous, registered storage, full/empty flags.
// Latency: a pushed entry is visible at pop_data one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop same cycle both act.
module kmeans_cmd_fifo
    import kmeans_apb_pkg::*;
#(
    parameter int WIDTH = 1 + DEF_ADDR_WIDTH + DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array: data only, no reset needed since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kmeans_apb_master.sv
// Queued command -> APB master: one transfer at a time, strictly in acceptance order.
// Latency: accept in cycle k -> SETUP k+2, ACCESS k+3, response earliest k+4.
// Backpressure: cmd_ready = FIFO not full; response held until rsp_ready, no new SETUP meanwhile.
module kmeans_apb_master
    import kmeans_apb_pkg::*;
#(
    parameter int addrWidth      = DEF_ADDR_WIDTH,
    parameter int dataWidth      = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_timeout,
    output logic [addrWidth-1:0] paddr,
    output logic                 pwrite,
    output logic                 psel,
    output logic                 penable,
    output logic [dataWidth-1:0] pwdata,
    input  logic [dataWidth-1:0] prdata,
    input  logic                 pready
);

    localparam int CW = 1 + addrWidth + dataWidth;
    localparam int TW = timer_width(TIMEOUT_CYCLES);
    // Value of the wait counter during the last ACCESS cycle we are allowed.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    apb_state_t     state;
    apb_state_t     state_nxt;
    logic [CW-1:0]  fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic [TW-1:0]  timer;
    logic           xfer_ok;
    logic           xfer_timeout;
    logic           rsp_done;

    kmeans_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data ({cmd_write, cmd_addr, cmd_wdata}),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty)
    );

    // Readiness depends only on occupancy so the host never sees a pop-dependent path.
    assign cmd_ready = !fifo_full;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and APB/response strobes, decoded from the current state.
    always_comb begin
        state_nxt    = state;
        fifo_pop     = 1'b0;
        xfer_ok      = 1'b0;
        xfer_timeout = 1'b0;
        rsp_done     = 1'b0;
        psel         = 1'b0;
        penable      = 1'b0;
        rsp_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                // pready wins even in the final permitted cycle.
                if (pready) begin
                    xfer_ok   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (timer == TIMER_LAST) begin
                    xfer_timeout = 1'b1;
                    state_nxt    = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ACCESS wait counter: cleared as the transfer enters SETUP, stops at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (fifo_pop) begin
            timer <= '0;
        end else if ((state == ST_ACCESS) && !pready && !xfer_timeout) begin
            timer <= timer + 1'b1;
        end
    end

    // Latch the popped command; APB address/data stay put for the whole transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (fifo_pop) begin
            {pwrite, paddr, pwdata} <= fifo_head;
        end
    end

    // Capture the transfer outcome; writes and timeouts report zero read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else if (xfer_ok) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_timeout <= 1'b0;
        end else if (xfer_timeout) begin
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
        end else if (rsp_done) begin
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end
    end

endmodule
